sm_ram_loader: RTL and testbench

//  Upstream feeder for sm_top's user RAM port. Takes a byte stream (e.g. from a UART

---
 rtl/sm_ram_loader.sv | 148 ++++++++++++++
 tb/tb_sm_ram_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_ram_loader.sv
// sm_ram_loader
//   Receives a byte stream (16-bit LE word count N, then N little-endian
//   32-bit words), writes each word into the user RAM port of sm_top and
//   reads it straight back to confirm it. The CPU is held in reset until a
//   load completes successfully.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a new load (ignored while busy)
//   byte_valid/_data    stream byte in; byte_ready accepts it
//   userAddr/We/WData   RAM write port (word address)
//   userRData           combinational RAM read of userAddr
//   cpu_rst_n           CPU reset, high only after a successful load
//   busy, done, error   load status; word_count = words written and verified
module sm_ram_loader #(
  parameter logic [31:0] BASE_WORD  = 32'd0,
  parameter int unsigned WORD_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] userAddr,
  output logic        userWe,
  output logic [31:0] userWData,
  input  logic [31:0] userRData,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, BYTES, WRITE, CHECK, DONE, ERROR
  } state_t;

  state_t      state, nextState;
  logic [7:0]  nLo;
  logic [15:0] nWords;
  logic [1:0]  byteIdx;
  logic [15:0] wordCount;
  logic [31:0] wData;

  logic [15:0] hdrN;
  logic [15:0] countInc;
  logic        checkOk;
  logic        acceptByte;
  logic        startOk;

  assign hdrN       = {byte_data, nLo};
  assign countInc   = wordCount + 16'd1;
  assign checkOk    = (userRData == wData);
  // Derived from state rather than byte_ready to keep the comb block acyclic.
  assign acceptByte = byte_valid && (state == HDR0 || state == HDR1 || state == BYTES);
  assign startOk    = start && (state == IDLE || state == DONE || state == ERROR);

  assign userAddr   = BASE_WORD + {16'h0000, wordCount};
  assign userWData  = wData;
  assign word_count = wordCount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState  = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    userWe     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state)
      IDLE: if (start) nextState = HDR0;
      HDR0: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) nextState = HDR1;
      end
      HDR1: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (hdrN == 16'd0)                        nextState = DONE;
          else if ({16'h0000, hdrN} > WORD_LIMIT)   nextState = ERROR;
          else                                      nextState = BYTES;
        end
      end
      BYTES: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && byteIdx == 2'd3) nextState = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        userWe    = 1'b1;
        nextState = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (!checkOk)                nextState = ERROR;
        else if (countInc == nWords) nextState = DONE;
        else                         nextState = BYTES;
      end
      DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
        if (start) nextState = HDR0;
      end
      ERROR: begin
        error = 1'b1;
        if (start) nextState = HDR0;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nLo       <= '0;
      nWords    <= '0;
      byteIdx   <= '0;
      wordCount <= '0;
      wData     <= '0;
    end else begin
      if (startOk) begin
        wordCount <= '0;
        byteIdx   <= '0;
      end
      if (acceptByte) begin
        case (state)
          HDR0:    nLo    <= byte_data;
          HDR1:    nWords <= hdrN;
          BYTES: begin
            wData[{byteIdx, 3'b000} +: 8] <= byte_data;
            byteIdx <= byteIdx + 2'd1;
          end
          default: ;
        endcase
      end
      if (state == CHECK && checkOk) wordCount <= countInc;
    end
  end

endmodule

// File: tb/tb_sm_ram_loader.sv
module tb_sm_ram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [31:0] userAddr;
  logic        userWe;
  logic [31:0] userWData;
  logic [31:0] userRData;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int vectors = 0;
  int fails = 0;

  // RAM model with optional single-bit corruption of the readback of word 1
  logic [31:0] mem [0:63];
  logic        corrupt = 1'b0;
  int          weCount = 0;
  int          accCount = 0;
  logic [31:0] weAddr [0:31];

  always #5 clk = ~clk;

  sm_ram_loader #(.BASE_WORD(32'd0), .WORD_LIMIT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .userAddr(userAddr), .userWe(userWe), .userWData(userWData), .userRData(userRData),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  assign userRData = mem[userAddr[5:0]] ^ {31'd0, (corrupt && userAddr == 32'd1)};

  always @(posedge clk) begin
    if (userWe) begin
      mem[userAddr[5:0]] <= userWData;
      weAddr[weCount[4:0]] <= userAddr;
      weCount <= weCount + 1;
    end
    if (byte_valid && byte_ready) accCount <= accCount + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks begin and end just after a negative edge.
  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    logic ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 100; i++) begin
      if (byte_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic sendHdr(input logic [15:0] n);
    sendByte(n[7:0], 0);
    sendByte(n[15:8], 0);
  endtask

  task automatic sendWord(input logic [31:0] w, input logic randGap);
    for (int k = 0; k < 4; k++)
      sendByte(w[8*k +: 8], randGap ? int'($urandom_range(0, 5)) : 0);
  endtask

  int weBase, accBase;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_userAddr", userAddr, 32'd0);
    chk("rst_userWe", {31'd0, userWe}, 32'd0);
    chk("rst_userWData", userWData, 32'd0);
    chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    chk("rst_status", {29'd0, busy, done, error}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: N=2, two words
    doStart();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    sendHdr(16'd2);
    sendWord(32'h00110011, 1'b0);
    chk("t1_w0_we", {31'd0, userWe}, 32'd1);
    chk("t1_w0_addr", userAddr, 32'd0);
    chk("t1_w0_data", userWData, 32'h00110011);
    sendWord(32'hDEADBEEF, 1'b0);
    chk("t1_w1_we", {31'd0, userWe}, 32'd1);
    chk("t1_w1_addr", userAddr, 32'd1);
    @(negedge clk);
    chk("t1_check_we", {31'd0, userWe}, 32'd0);
    chk("t1_t2_cpu", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    chk("t1_done", {29'd0, busy, done, error}, 32'b010);
    chk("t1_cpu", {31'd0, cpu_rst_n}, 32'd1);
    chk("t1_count", {16'd0, word_count}, 32'd2);
    chk("t1_we_pulses", weCount, 32'd2);
    chk("t1_we_addr0", weAddr[0], 32'd0);
    chk("t1_we_addr1", weAddr[1], 32'd1);
    chk("t1_mem0", mem[0], 32'h00110011);
    chk("t1_mem1", mem[1], 32'hDEADBEEF);

    // 2: N=0
    weBase = weCount;
    doStart();
    chk("t2_cleared", {30'd0, done, cpu_rst_n}, 32'd0);
    sendHdr(16'd0);
    chk("t2_done", {29'd0, busy, done, error}, 32'b010);
    chk("t2_cpu", {31'd0, cpu_rst_n}, 32'd1);
    chk("t2_count", {16'd0, word_count}, 32'd0);
    chk("t2_no_we", weCount - weBase, 32'd0);

    // 3: N=65 exceeds limit
    doStart();
    sendHdr(16'd65);
    chk("t3_error", {29'd0, busy, done, error}, 32'b001);
    chk("t3_ready", {31'd0, byte_ready}, 32'd0);
    chk("t3_cpu", {31'd0, cpu_rst_n}, 32'd0);
    accBase = accCount;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (5) @(negedge clk);
    chk("t3_stall", accCount - accBase, 32'd0);
    byte_valid = 1'b0;

    // 4: N=1 with random gaps
    weBase = weCount;
    doStart();
    accBase = accCount;
    sendByte(8'h01, int'($urandom_range(0, 5)));
    sendByte(8'h00, int'($urandom_range(0, 5)));
    sendWord(32'hCAFEF00D, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_done", {29'd0, busy, done, error}, 32'b010);
    chk("t4_count", {16'd0, word_count}, 32'd1);
    chk("t4_mem0", mem[0], 32'hCAFEF00D);
    chk("t4_bytes", accCount - accBase, 32'd6);
    chk("t4_we", weCount - weBase, 32'd1);

    // 5: corrupted readback of word 1, then clean reload
    corrupt = 1'b1;
    doStart();
    sendHdr(16'd3);
    sendWord(32'h11111111, 1'b0);
    sendWord(32'h22222222, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_error", {29'd0, busy, done, error}, 32'b001);
    chk("t5_count", {16'd0, word_count}, 32'd1);
    chk("t5_cpu", {31'd0, cpu_rst_n}, 32'd0);
    corrupt = 1'b0;
    doStart();
    sendHdr(16'd3);
    sendWord(32'h11111111, 1'b0);
    sendWord(32'h22222222, 1'b0);
    sendWord(32'h33333333, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_reload", {29'd0, busy, done, error}, 32'b010);
    chk("t5_reload_count", {16'd0, word_count}, 32'd3);
    chk("t5_mem2", mem[2], 32'h33333333);

    // 6: async reset after 2 payload bytes
    weBase = weCount;
    doStart();
    sendHdr(16'd1);
    sendByte(8'hAA, 0);
    sendByte(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_ready", {31'd0, byte_ready}, 32'd0);
    chk("t6_addr", userAddr, 32'd0);
    chk("t6_we", {31'd0, userWe}, 32'd0);
    chk("t6_wdata", userWData, 32'd0);
    chk("t6_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("t6_status", {29'd0, busy, done, error}, 32'd0);
    chk("t6_count", {16'd0, word_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_we", weCount - weBase, 32'd0);
    doStart();
    sendHdr(16'd1);
    sendWord(32'h13579BDF, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_reload", {29'd0, busy, done, error}, 32'b010);
    chk("t6_reload_cpu", {31'd0, cpu_rst_n}, 32'd1);
    chk("t6_mem0", mem[0], 32'h13579BDF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
